// File: rtl/veri_risc_core_if.sv
// Memory bus between the accumulator core (master) and memory/fabric (slave).
// req/ack handshake; a transfer completes on the edge where req and ack are both high.
interface veri_risc_core_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) ();
  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/veri_risc_core.sv
// Multi-cycle accumulator processor: FETCH/DECODE/EXEC/HALT over a handshaked bus,
// with resumable halt, sticky bus-timeout error and a retired-instruction counter.
module veri_risc_core #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 5,
  parameter int RESET_PC  = 0,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  veri_risc_core_if.master     bus,
  output logic                 halt,
  output logic                 bus_err,
  output logic [AWIDTH-1:0]    pc,
  output logic [DWIDTH-1:0]    ac,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t                state_q, state_d;
  logic [AWIDTH-1:0]     pc_q, pc_d;
  logic [DWIDTH-1:0]     ac_q, ac_d;
  logic [DWIDTH-1:0]     ir_q, ir_d;
  logic [CNT_WIDTH-1:0]  ret_q, ret_d;
  logic                  halt_q, halt_d;
  logic                  err_q, err_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [2:0]            opcode;
  logic [AWIDTH-1:0]     opa;
  logic                  xfer;
  logic                  timed_out;

  function automatic logic [DWIDTH-1:0] alu(input logic [2:0] op,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] m);
    case (op)
      OP_ADD:  return a + m;
      OP_AND:  return a & m;
      OP_XOR:  return a ^ m;
      default: return m;
    endcase
  endfunction

  assign opcode    = ir_q[DWIDTH-1 -: 3];
  assign opa       = ir_q[AWIDTH-1:0];
  assign xfer      = req_q & bus.mem_ack;
  assign timed_out = (TIMEOUT > 0) && req_q && !bus.mem_ack && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    halt_d  = halt_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Wait counter restarts with every new request and only runs while stalled.
    tmo_d   = (TIMEOUT > 0 && req_q && !bus.mem_ack) ? tmo_q + 1'b1 : '0;

    case (state_q)
      S_FETCH: begin
        req_d  = 1'b1;
        we_d   = 1'b0;
        addr_d = pc_q;
        if (xfer) begin
          ir_d    = bus.mem_rdata;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
        // Outputs are registered, so the operand transfer is launched on entry to EXEC.
        if (opcode != OP_HLT && opcode != OP_SKZ && opcode != OP_JMP) begin
          req_d   = 1'b1;
          we_d    = (opcode == OP_STO);
          addr_d  = opa;
          wdata_d = ac_q;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_HLT: begin
            ret_d   = ret_q + 1'b1;
            halt_d  = 1'b1;
            state_d = S_HALT;
          end
          OP_SKZ: begin
            ret_d   = ret_q + 1'b1;
            if (ac_q == '0) pc_d = pc_q + 1'b1;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = pc_d;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            ret_d   = ret_q + 1'b1;
            pc_d    = opa;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = opa;
            state_d = S_FETCH;
          end
          default: begin
            if (xfer) begin
              if (opcode != OP_STO) ac_d = alu(opcode, ac_q, bus.mem_rdata);
              ret_d   = ret_q + 1'b1;
              we_d    = 1'b0;
              addr_d  = pc_q;
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_HALT: begin
        if (go && !err_q) begin
          halt_d  = 1'b0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (timed_out) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b1;
      halt_d  = 1'b1;
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= AWIDTH'(RESET_PC);
      ac_q    <= '0;
      ir_q    <= '0;
      ret_q   <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign halt          = halt_q;
  assign bus_err       = err_q;
  assign pc            = pc_q;
  assign ac            = ac_q;
  assign retired       = ret_q;

endmodule

// File: tb/tb_veri_risc_core.sv
// Directed bench for veri_risc_core: memory responder with programmable ack delay,
// bus-transfer scoreboard, and architectural state checks after each program.
module tb_veri_risc_core;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        halt, bus_err;
  logic [4:0]  pc;
  logic [7:0]  ac;
  logic [15:0] retired;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mem [32];
  xfer_t       sb [$];
  bit          ack_en = 1'b1;
  int          ack_dly = 0;
  int          wcnt = 0;
  logic        hold_we;
  logic [4:0]  hold_addr;
  logic [7:0]  hold_wdata;

  veri_risc_core_if #(.DWIDTH(8), .AWIDTH(5)) bus ();

  veri_risc_core #(.DWIDTH(8), .AWIDTH(5), .RESET_PC(0), .TIMEOUT(8), .CNT_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .go      (go),
    .bus     (bus),
    .halt    (halt),
    .bus_err (bus_err),
    .pc      (pc),
    .ac      (ac),
    .retired (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input logic [4:0] a);
    xfer_t x;
    x.we = 1'b0; x.addr = a; x.wdata = 8'h00;
    sb.push_back(x);
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [7:0] d);
    xfer_t x;
    x.we = 1'b1; x.addr = a; x.wdata = d;
    sb.push_back(x);
  endtask

  // Memory responder: decides ack on the falling edge so it is stable at the next rising edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && rst_n) begin
        if (wcnt == 0) begin
          hold_we = bus.mem_we; hold_addr = bus.mem_addr; hold_wdata = bus.mem_wdata;
        end
        if (ack_en && wcnt >= ack_dly) begin
          if (ack_dly > 0) begin
            chk("stable_we",   bus.mem_we,   hold_we);
            chk("stable_addr", bus.mem_addr, hold_addr);
            if (bus.mem_we) chk("stable_wdata", bus.mem_wdata, hold_wdata);
          end
          n_tests++;
          assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed=addr %0h we %0b expected=no transfer", bus.mem_addr, bus.mem_we);
          end
          if (sb.size() > 0) begin
            xfer_t e;
            e = sb.pop_front();
            chk("xfer_we",   bus.mem_we,   e.we);
            chk("xfer_addr", bus.mem_addr, e.addr);
            if (e.we) chk("xfer_wdata", bus.mem_wdata, e.wdata);
          end
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = mem[bus.mem_addr];
          bus.mem_ack   = 1'b1;
          wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic do_reset(input int dly, input bit en);
    @(negedge clk);
    rst_n = 1'b0;
    go = 1'b0;
    sb.delete();
    ack_dly = dly;
    ack_en = en;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns rising edges from the first mem_req to halt being seen high.
  task automatic run_to_halt(output int cyc);
    int n = 0;
    int first = -1;
    while (!halt && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (first < 0 && bus.mem_req) first = n;
    end
    chk("halt_reached", halt, 1'b1);
    cyc = n - first;
  endtask

  task automatic load_prog2();
    mem[0] = 8'hB0; mem[1] = 8'h51; mem[2] = 8'hD2; mem[3] = 8'h00;
    mem[5'h10] = 8'h05; mem[5'h11] = 8'h03;
  endtask

  initial begin
    int cyc;
    int hi;

    // Reset state, then abort a stalled fetch with an asynchronous reset.
    do_reset(0, 1'b1);
    load_prog2();
    exp_rd(5'h00); exp_rd(5'h10); exp_rd(5'h01); exp_rd(5'h11);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    repeat (7) @(posedge clk);
    ack_en = 1'b0;
    #1;
    chk("pre_abort_ac", ac, 8'h08);
    chk("pre_abort_ret", retired, 16'd2);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_abort_req", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_req", bus.mem_req, 1'b0);
    chk("abort_pc", pc, 5'h00);
    chk("abort_ac", ac, 8'h00);
    chk("abort_ret", retired, 16'd0);
    chk("abort_sb", sb.size(), 0);

    // LDA/ADD/STO/HLT with zero-wait memory: 3 cycles per instruction.
    do_reset(0, 1'b1);
    load_prog2();
    exp_rd(5'h00); exp_rd(5'h10); exp_rd(5'h01); exp_rd(5'h11);
    exp_rd(5'h02); exp_wr(5'h12, 8'h08); exp_rd(5'h03);
    run_to_halt(cyc);
    chk("t2_cycles", cyc, 12);
    chk("t2_mem12", mem[5'h12], 8'h08);
    chk("t2_ac", ac, 8'h08);
    chk("t2_pc", pc, 5'h04);
    chk("t2_ret", retired, 16'd4);
    chk("t2_sb", sb.size(), 0);

    // Same program, 3 wait states on each of the 7 transfers.
    do_reset(3, 1'b1);
    load_prog2();
    exp_rd(5'h00); exp_rd(5'h10); exp_rd(5'h01); exp_rd(5'h11);
    exp_rd(5'h02); exp_wr(5'h12, 8'h08); exp_rd(5'h03);
    run_to_halt(cyc);
    chk("t4_cycles", cyc, 12 + 3 * 7);
    chk("t4_mem12", mem[5'h12], 8'h08);
    chk("t4_ac", ac, 8'h08);
    chk("t4_ret", retired, 16'd4);
    chk("t4_sb", sb.size(), 0);

    // SKZ with ac==0 skips the JMP.
    do_reset(0, 1'b1);
    mem[0] = 8'hB0; mem[1] = 8'h20; mem[2] = 8'hFE; mem[5'h10] = 8'h00;
    exp_rd(5'h00); exp_rd(5'h10); exp_rd(5'h01); exp_rd(5'h03);
    run_to_halt(cyc);
    chk("t3a_pc", pc, 5'h04);
    chk("t3a_ret", retired, 16'd3);
    chk("t3a_sb", sb.size(), 0);

    // SKZ with ac!=0 falls through to JMP 1Eh.
    do_reset(0, 1'b1);
    mem[0] = 8'hB0; mem[1] = 8'h20; mem[2] = 8'hFE; mem[5'h10] = 8'h01;
    exp_rd(5'h00); exp_rd(5'h10); exp_rd(5'h01); exp_rd(5'h02); exp_rd(5'h1E);
    run_to_halt(cyc);
    chk("t3b_pc", pc, 5'h1F);
    chk("t3b_ac", ac, 8'h01);
    chk("t3b_ret", retired, 16'd4);
    chk("t3b_sb", sb.size(), 0);

    // Timeout: no ack ever; go afterwards must be ignored.
    do_reset(0, 1'b0);
    hi = 0;
    for (int i = 0; i < 30 && !bus_err; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) hi++;
    end
    chk("t5_req_cycles", hi, 8);
    chk("t5_err", bus_err, 1'b1);
    chk("t5_halt", halt, 1'b1);
    chk("t5_req", bus.mem_req, 1'b0);
    chk("t5_ret", retired, 16'd0);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_go_halt", halt, 1'b1);
    chk("t5_go_req", bus.mem_req, 1'b0);
    chk("t5_go_pc", pc, 5'h00);

    // PC wrap through 1Fh, XOR/AND, and resume after HLT with go.
    do_reset(0, 1'b1);
    ack_en = 1'b1;
    mem[0] = 8'h20; mem[1] = 8'hE4; mem[2] = 8'hFF; mem[5'h1F] = 8'hB0;
    mem[4] = 8'h91; mem[5] = 8'h00; mem[6] = 8'h72; mem[7] = 8'h00;
    mem[5'h10] = 8'h07; mem[5'h11] = 8'h0F; mem[5'h12] = 8'h0C;
    exp_rd(5'h00); exp_rd(5'h02); exp_rd(5'h1F); exp_rd(5'h10); exp_rd(5'h00);
    exp_rd(5'h01); exp_rd(5'h04); exp_rd(5'h11); exp_rd(5'h05);
    exp_rd(5'h06); exp_rd(5'h12); exp_rd(5'h07);
    run_to_halt(cyc);
    chk("t6_pc", pc, 5'h06);
    chk("t6_ac", ac, 8'h08);
    chk("t6_ret", retired, 16'd7);
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1;
    chk("t6_go_halt", halt, 1'b0);
    chk("t6_go_req", bus.mem_req, 1'b1);
    chk("t6_go_addr", bus.mem_addr, 5'h06);
    @(negedge clk); go = 1'b0;
    run_to_halt(cyc);
    chk("t6_end_ac", ac, 8'h08);
    chk("t6_end_pc", pc, 5'h08);
    chk("t6_end_ret", retired, 16'd9);
    chk("t6_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
